fir_post_decim: RTL
===================

Name: fir_post_decim

Overview:
Downstream stage of the `fir` filter. It consumes the 19-bit `io_y`/`io_valid_out` stream and integrates DECIM consecutive valid samples. Each block sum is scaled down, optionally rounded, and saturated to an 8-bit output sample. Results are buffered in a small FIFO with a ready/valid output, so a slow consumer can drain them. The upstream FIR has no backpressure, so this block never stalls its input.

Parameters:
- IN_W, 19, input sample width (matches `fir` `io_y`)
- OUT_W, 8, output sample width
- DECIM, 4, samples per output; must be a power of 2, >= 2
- SHIFT, 11, extra right shift applied after averaging
- DEPTH, 4, output FIFO entries; must be a power of 2, >= 2

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- io_valid_in  input  1  input sample valid; wired to `fir` `io_valid_out`
- io_y  input  IN_W  unsigned input sample; wired to `fir` `io_y`
- io_valid_out  output  1  FIFO not empty
- io_ready  input  1  consumer ready
- io_data  output  OUT_W  FIFO head sample
- io_overflow  output  1  sticky: a result was dropped
- io_count  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (`reset` = 0, asynchronous assert, synchronous deassert is the caller's job):
  - accumulator = 0, phase counter = 0, result register empty
  - FIFO empty: `io_valid_out` = 0, `io_count` = 0, `io_data` = 0
  - `io_overflow` = 0
  - Reset mid-block discards the partial sum and all FIFO contents.
- Accumulate: on each edge with `io_valid_in` = 1:
  - acc += `io_y`; acc is IN_W + log2(DECIM) bits wide, unsigned, and cannot overflow.
  - phase increments, wrapping at DECIM.
  - Cycles with `io_valid_in` = 0 hold acc and phase; gaps are allowed.
- Completion: on the edge accepting the phase = DECIM-1 sample:
  - The full sum (acc + `io_y`) is latched into the result register.
  - acc clears to 0 and phase to 0 in the same edge; no sample is lost between blocks.
- Scale: TS = log2(DECIM) + SHIFT; r = sum >> TS.
- Saturate: if r > 2^OUT_W - 1, r = 2^OUT_W - 1.
- Push: on the next edge the result register is pushed to the FIFO.
  - Latency: last input edge -> `io_valid_out` high after 2 edges, if the FIFO was empty.
- Pop: the handshake completes on an edge where `io_valid_out` && `io_ready`.
  - `io_data` shows the head combinationally from the FIFO registers.
  - `io_data` is stable while `io_valid_out` = 1 and `io_ready` = 0.
- Boundary conditions:
  - Push and pop in the same cycle when full: both succeed; count unchanged.
  - Push when full with no pop: result dropped, `io_overflow` set; it stays set until reset.
  - Pop when empty: ignored.
  - Push and pop when empty: the pushed entry is not visible until the next cycle (no bypass).
  - FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: `FIR_POST_ROUND_EN`
- Defined: round-half-up, r = (sum + 2^(TS-1)) >> TS, computed one bit wider, then saturated.
- Undefined: truncation, r = sum >> TS.
- Latency and the interface are identical in both builds.

Decomposition:
- Package `fir_pkg`:
  - localparams FIR_IN_W = 19, FIR_X_W = 8
  - function `sat_u(value, width)`
- Sub-module `fir_post_fifo`:
  - synchronous FIFO, parameterised width/depth, same clock/reset
  - push/pop/full/empty/count
- The top holds the accumulator, phase counter, scaler and overflow flag.

Test Plan:
- Reset hold: `reset` = 0 with random `io_y`/`io_valid_in` -> all outputs 0; `io_count` = 0.
- Basic: `io_y` = 2048 x4 with valid, `io_ready` = 1 -> one output, `io_data` = 1, `io_valid_out` high 2 edges after the 4th input.
- Rounding: `io_y` = 2048, 2048, 2048, 1024 -> `io_data` = 0 without the macro, 1 with `FIR_POST_ROUND_EN`.
- Saturation: `io_y` = 524287 x4 -> `io_data` = 255 in both builds.
- Backpressure:
  - Stimulus: `io_ready` = 0; 5 blocks of sequence inputs 8192·k x4, for k = 1..5.
  - After 4 blocks: `io_count` = 4, `io_overflow` = 0.
  - After the 5th block: `io_overflow` = 1.
  - Then `io_ready` = 1: pops yield 4, 8, 12, 16 in order, then `io_valid_out` = 0.
- Gaps and reset mid-block:
  - Inputs with `io_valid_in` toggling 1010... still produce 1 output per 4 valid samples.
  - Asserting `reset` after 2 samples, then feeding 4 more samples of 2048 -> `io_data` = 1 (the partial sum was discarded).

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and helpers for the fir filter and its post-decimation stage.
package fir_pkg;

    localparam int FIR_IN_W = 19;
    localparam int FIR_X_W  = 8;

    // Clamp an unsigned value to the largest number representable in 'width' bits.
    function automatic logic [31:0] sat_u(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value > max_v) ? max_v : value;
    endfunction

endpackage

// File: rtl/fir_post_decim_if.sv
// Stream interface of fir_post_decim: FIR sample input, ready/valid output, status.
interface fir_post_decim_if
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_X_W,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              io_valid_in;
    logic [IN_W-1:0]   io_y;
    logic              io_valid_out;
    logic              io_ready;
    logic [OUT_W-1:0]  io_data;
    logic              io_overflow;
    logic [CNT_W-1:0]  io_count;

    modport master (
        output io_valid_in, io_y, io_ready,
        input  io_valid_out, io_data, io_overflow, io_count
    );

    modport slave (
        input  io_valid_in, io_y, io_ready,
        output io_valid_out, io_data, io_overflow, io_count
    );

endinterface

// File: rtl/fir_post_fifo.sv
// Synchronous FIFO with occupancy count; head is shown combinationally, no bypass.
module fir_post_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = FIR_X_W,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_q, wr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A pop frees the slot the simultaneous push needs, so full + pop still accepts.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign count_o = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    // NOTE: storage is not reset; empty masks stale entries, keeping data_o at 0 after reset.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/fir_post_decim.sv
// Integrate-and-dump decimator behind the fir filter: sums DECIM samples, scales,
// saturates and queues results. Define FIR_POST_ROUND_EN for round-half-up scaling.
module fir_post_decim
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_X_W,
    parameter int DECIM = 4,
    parameter int SHIFT = 11,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    fir_post_decim_if.slave  bus
);
    localparam int LOG_D = $clog2(DECIM);
    localparam int ACC_W = IN_W + LOG_D;
    localparam int TS    = LOG_D + SHIFT;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [LOG_D-1:0] phase_q, phase_d;
    logic [OUT_W-1:0] res_q, res_d, sat_val;
    logic             res_vld_q, res_vld_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   scaled;
    logic             last;
    logic             pop;
    logic             fifo_full, fifo_empty;
    logic [OUT_W-1:0] fifo_data;
    logic [CNT_W-1:0] fifo_count;

    assign sum  = acc_q + ACC_W'(bus.io_y);
    assign last = bus.io_valid_in && (phase_q == LOG_D'(DECIM - 1));

`ifdef FIR_POST_ROUND_EN
    assign scaled = ({1'b0, sum} + ((ACC_W+1)'(1) << (TS - 1))) >> TS;
`else
    assign scaled = {1'b0, sum} >> TS;
`endif
    assign sat_val = OUT_W'(sat_u(32'(scaled), OUT_W));

    assign pop = !fifo_empty && bus.io_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_d     = acc_q;
        phase_d   = phase_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        ovf_d     = ovf_q;
        if (bus.io_valid_in) begin
            if (last) begin
                acc_d     = '0;
                phase_d   = '0;
                res_d     = sat_val;
                res_vld_d = 1'b1;
            end else begin
                acc_d   = sum;
                phase_d = phase_q + LOG_D'(1);
            end
        end
        if (res_vld_q && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            phase_q   <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            phase_q   <= phase_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            ovf_q     <= ovf_d;
        end
    end

    fir_post_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (res_vld_q),
        .pop_i   (pop),
        .data_i  (res_q),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.io_valid_out = !fifo_empty;
    assign bus.io_data      = fifo_data;
    assign bus.io_count     = fifo_count;
    assign bus.io_overflow  = ovf_q;

endmodule
